// File: rtl/ntsc_packer.sv
// ntsc_packer: packs decoded pixel pairs into memory words, buffers them in a FIFO,
// drives the ntsc_flag/done_ntsc write handshake and pads short frames to FRAME_WORDS.
module ntsc_packer #(
  parameter int PIXEL_W      = 18,
  parameter int MEM_W        = 36,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int FRAME_WORDS  = IMAGE_WIDTH * IMAGE_HEIGHT / 2,
  parameter int CNT_W        = 18,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pixel_valid,
  input  logic [PIXEL_W-1:0] pixel,
  input  logic               sof,
  output logic               ntsc_flag,
  output logic [MEM_W-1:0]   ntsc_pixel,
  input  logic               done_ntsc,
  output logic               frame_flag,
  output logic               overflow_err,
  output logic               pad_err,
  output logic [2:0]         debug_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CAPT  = 3'd1;
  localparam logic [2:0] ST_PAD   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [AW:0]        FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   FRAME_CNT = CNT_W'(FRAME_WORDS);
  localparam logic [MEM_W-1:0]   ZERO_WORD = {MEM_W{1'b0}};

  logic [2:0]         r_state;
  logic               r_half;
  logic [PIXEL_W-1:0] r_even;
  logic [CNT_W-1:0]   r_word_cnt;
  logic               r_overflow_err;
  logic               r_pad_err;
  logic [MEM_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;

  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_accept;
  logic [MEM_W-1:0]   w_push_word;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_empty   = (r_count == {(AW+1){1'b0}});
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = done_ntsc && !w_empty;
  assign w_accept  = w_push && (!w_full || w_pop);
  assign w_cnt_inc = r_word_cnt + CNT_W'(1);

  assign ntsc_flag    = !w_empty;
  assign ntsc_pixel   = w_empty ? ZERO_WORD : r_mem[r_rd_ptr];
  assign frame_flag   = (r_state == ST_DONE);
  assign overflow_err = r_overflow_err;
  assign pad_err      = r_pad_err;
  assign debug_state  = r_state;

  // A push request is a completed pixel pair in CAPT or a zero word in PAD.
  always_comb begin
    w_push      = 1'b0;
    w_push_word = ZERO_WORD;
    case (r_state)
      ST_CAPT: begin
        if (pixel_valid && !sof && r_half) begin
          w_push      = 1'b1;
          w_push_word = {r_even, pixel};
        end else begin
          w_push      = 1'b0;
        end
      end
      ST_PAD: begin
        if (r_word_cnt != FRAME_CNT) begin
          w_push = 1'b1;
        end else begin
          w_push = 1'b0;
        end
      end
      default: w_push = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_half         <= 1'b0;
      r_even         <= {PIXEL_W{1'b0}};
      r_word_cnt     <= {CNT_W{1'b0}};
      r_overflow_err <= 1'b0;
      r_pad_err      <= 1'b0;
    end else begin
      if (w_push && !w_accept) begin
        r_overflow_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (pixel_valid && sof) begin
            r_even     <= pixel;
            r_half     <= 1'b1;
            r_word_cnt <= {CNT_W{1'b0}};
            r_state    <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          if (pixel_valid) begin
            if (sof) begin
              // Interrupted frame: drop the half pair and pad out the remainder.
              r_pad_err <= 1'b1;
              r_half    <= 1'b0;
              r_state   <= ST_PAD;
            end else if (!r_half) begin
              r_even <= pixel;
              r_half <= 1'b1;
            end else begin
              r_half <= 1'b0;
            end
          end
          if (w_accept) begin
            r_word_cnt <= w_cnt_inc;
            if (w_cnt_inc == FRAME_CNT) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_PAD: begin
          if (r_word_cnt == FRAME_CNT) begin
            r_state <= ST_DRAIN;
          end else if (w_accept) begin
            r_word_cnt <= w_cnt_inc;
            if (w_cnt_inc == FRAME_CNT) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping; a pop frees the slot a same-cycle push lands in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - (AW+1)'(1);
      end else begin
        r_count <= r_count;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= w_push_word;
    end
  end

endmodule

// File: tb/tb_ntsc_packer.sv
// Randomised and directed bench for ntsc_packer: two instances (FIFO depth 4 and 2)
// share one input stream and are compared each cycle against a queue-level model.
module tb_ntsc_packer;

  localparam int M_IDLE  = 0;
  localparam int M_CAPT  = 1;
  localparam int M_PAD   = 2;
  localparam int M_DRAIN = 3;
  localparam int M_DONE  = 4;
  localparam int FW      = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        pixel_valid;
  logic [17:0] pixel;
  logic        sof;
  logic        done_ntsc;

  logic        a_flag, b_flag, a_ff, b_ff, a_ovf, b_ovf, a_pad, b_pad;
  logic [35:0] a_pix, b_pix;
  logic [2:0]  a_dbg, b_dbg;

  int n_chk = 0;
  int n_err = 0;
  int fc_a  = 0;
  int fc_b  = 0;
  logic [35:0] log_a[$];
  logic [35:0] log_b[$];
  logic [35:0] exp_q[$];

  // reference model state, index 0 = depth-4 instance, 1 = depth-2 instance
  int          m_mode  [2];
  int          m_n     [2];
  int          m_words [2];
  bit          m_have  [2];
  logic [17:0] m_even  [2];
  bit          m_ovf   [2];
  bit          m_pad   [2];
  logic [35:0] m_buf   [2][8];

  always #5 clock = ~clock;

  ntsc_packer #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .FIFO_DEPTH(4)) u_a (
    .clock(clock), .reset(reset), .pixel_valid(pixel_valid), .pixel(pixel), .sof(sof),
    .ntsc_flag(a_flag), .ntsc_pixel(a_pix), .done_ntsc(done_ntsc), .frame_flag(a_ff),
    .overflow_err(a_ovf), .pad_err(a_pad), .debug_state(a_dbg));

  ntsc_packer #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .FIFO_DEPTH(2)) u_b (
    .clock(clock), .reset(reset), .pixel_valid(pixel_valid), .pixel(pixel), .sof(sof),
    .ntsc_flag(b_flag), .ntsc_pixel(b_pix), .done_ntsc(done_ntsc), .frame_flag(b_ff),
    .overflow_err(b_ovf), .pad_err(b_pad), .debug_state(b_dbg));

  function automatic logic [35:0] pk(input int e, input int o);
    return {18'(e), 18'(o)};
  endfunction

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_words(input string tag, input logic [35:0] got[$], input logic [35:0] exp[$]);
    check_eq({tag, ".count"}, 36'(got.size()), 36'(exp.size()));
    for (int k = 0; k < exp.size(); k++) begin
      if (k < got.size()) check_eq($sformatf("%s.word%0d", tag, k), got[k], exp[k]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_n[i] = 0; m_words[i] = 0; m_have[i] = 0;
      m_even[i] = 18'd0;  m_ovf[i] = 0; m_pad[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic v, input logic [17:0] p, input logic s, input logic d);
    int depth = (i == 0) ? 4 : 2;
    int n = m_n[i];
    bit pop = d && (n > 0);
    bit push = 0;
    bit acc;
    logic [35:0] pw = 36'd0;
    case (m_mode[i])
      M_IDLE:  if (v && s) begin m_even[i] = p; m_have[i] = 1; m_words[i] = 0; m_mode[i] = M_CAPT; end
      M_CAPT:  if (v) begin
                 if (s) begin m_pad[i] = 1; m_have[i] = 0; m_mode[i] = M_PAD; end
                 else if (!m_have[i]) begin m_even[i] = p; m_have[i] = 1; end
                 else begin push = 1; pw = {m_even[i], p}; m_have[i] = 0; end
               end
      M_PAD:   push = 1;
      M_DRAIN: if (n == 0) m_mode[i] = M_DONE;
      default: m_mode[i] = M_IDLE;
    endcase
    acc = push && (n < depth || pop);
    if (push && !acc) m_ovf[i] = 1;
    if (pop) begin
      for (int k = 0; k < 7; k++) m_buf[i][k] = m_buf[i][k+1];
      n--;
    end
    if (acc) begin
      m_buf[i][n] = pw;
      n++;
      m_words[i]++;
      if (m_words[i] == FW) m_mode[i] = M_DRAIN;
    end
    m_n[i] = n;
  endtask

  task automatic cmp_one(input string pre, input int i, input logic flag, input logic [35:0] pix,
                         input logic ff, input logic ovf, input logic pad, input logic [2:0] dbg);
    check_eq({pre, ".ntsc_flag"},  36'(flag), 36'(m_n[i] > 0));
    check_eq({pre, ".ntsc_pixel"}, pix, (m_n[i] > 0) ? m_buf[i][0] : 36'd0);
    check_eq({pre, ".frame_flag"}, 36'(ff),   36'(m_mode[i] == M_DONE));
    check_eq({pre, ".overflow"},   36'(ovf),  36'(m_ovf[i]));
    check_eq({pre, ".pad_err"},    36'(pad),  36'(m_pad[i]));
    check_eq({pre, ".state"},      36'(dbg),  36'(m_mode[i]));
  endtask

  task automatic compare_outputs();
    cmp_one("a", 0, a_flag, a_pix, a_ff, a_ovf, a_pad, a_dbg);
    cmp_one("b", 1, b_flag, b_pix, b_ff, b_ovf, b_pad, b_dbg);
    if (a_ff) fc_a++;
    if (b_ff) fc_b++;
  endtask

  // one clock: drive at the falling edge, log writes, advance model, compare
  task automatic cyc(input logic v, input logic [17:0] p, input logic s, input logic d);
    pixel_valid = v; pixel = p; sof = s; done_ntsc = d;
    #1;
    if (a_flag && d) log_a.push_back(a_pix);
    if (b_flag && d) log_b.push_back(b_pix);
    @(posedge clock);
    model_step(0, v, p, s, d);
    model_step(1, v, p, s, d);
    @(negedge clock);
    compare_outputs();
  endtask

  task automatic do_reset();
    pixel_valid = 1'b0; pixel = 18'd0; sof = 1'b0; done_ntsc = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    compare_outputs();
    reset = 1'b1;
    log_a.delete(); log_b.delete();
    fc_a = 0; fc_b = 0;
  endtask

  task automatic idle(input int n, input logic d);
    for (int k = 0; k < n; k++) cyc(1'b0, 18'd0, 1'b0, d);
  endtask

  task automatic normal_frame();
    cyc(1'b1, 18'd1, 1'b1, 1'b1);
    for (int k = 2; k <= 8; k++) cyc(1'b1, 18'(k), 1'b0, 1'b1);
    idle(10, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: normal frame
    do_reset();
    normal_frame();
    exp_q = '{pk(1, 2), pk(3, 4), pk(5, 6), pk(7, 8)};
    check_words("s1.words", log_a, exp_q);
    check_eq("s1.frames", 36'(fc_a), 36'd1);
    check_eq("s1.pad_err", 36'(a_pad), 36'd0);
    check_eq("s1.overflow", 36'(a_ovf), 36'd0);

    // 2: backpressure until four words are queued, then pop every other cycle
    do_reset();
    cyc(1'b1, 18'd1, 1'b1, 1'b0);
    for (int k = 2; k <= 8; k++) cyc(1'b1, 18'(k), 1'b0, 1'b0);
    check_eq("s2.queued_flag", 36'(a_flag), 36'd1);
    for (int k = 0; k < 16; k++) cyc(1'b0, 18'd0, 1'b0, (k % 2) == 0);
    idle(6, 1'b1);
    check_words("s2.words", log_a, exp_q);
    check_eq("s2.overflow", 36'(a_ovf), 36'd0);
    check_eq("s2.frames", 36'(fc_a), 36'd1);

    // 6: depth-2 instance full while an odd pixel arrives together with a pop
    do_reset();
    cyc(1'b1, 18'd1, 1'b1, 1'b0);
    for (int k = 2; k <= 5; k++) cyc(1'b1, 18'(k), 1'b0, 1'b0);
    check_eq("s6.full_before", 36'(b_flag), 36'd1);
    cyc(1'b1, 18'd6, 1'b0, 1'b1);
    check_eq("s6.overflow", 36'(b_ovf), 36'd0);
    check_eq("s6.head", b_pix, pk(3, 4));
    cyc(1'b1, 18'd7, 1'b0, 1'b1);
    cyc(1'b1, 18'd8, 1'b0, 1'b1);
    idle(8, 1'b1);
    check_words("s6.words", log_b, exp_q);
    check_eq("s6.frames", 36'(fc_b), 36'd1);

    // 3: overflow on the depth-2 instance, then a new sof forces padding
    do_reset();
    cyc(1'b1, 18'd1, 1'b1, 1'b0);
    for (int k = 2; k <= 10; k++) cyc(1'b1, 18'(k), 1'b0, 1'b0);
    check_eq("s3.overflow", 36'(b_ovf), 36'd1);
    cyc(1'b0, 18'd0, 1'b0, 1'b1);
    cyc(1'b1, 18'd20, 1'b1, 1'b1);
    check_eq("s3.pad_state", 36'(b_dbg), 36'd2);
    idle(12, 1'b1);
    check_words("s3.words", log_b, '{pk(1, 2), pk(3, 4), 36'd0, 36'd0});
    check_eq("s3.pad_err", 36'(b_pad), 36'd1);
    check_eq("s3.frames", 36'(fc_b), 36'd1);

    // 4: short frame interrupted by a second sof
    do_reset();
    cyc(1'b1, 18'd1, 1'b1, 1'b1);
    cyc(1'b1, 18'd2, 1'b0, 1'b1);
    cyc(1'b1, 18'd3, 1'b0, 1'b1);
    cyc(1'b1, 18'd9, 1'b1, 1'b1);
    for (int k = 10; k <= 15; k++) cyc(1'b1, 18'(k), 1'b0, 1'b1);
    idle(10, 1'b1);
    check_words("s4.words", log_a, '{pk(1, 2), 36'd0, 36'd0, 36'd0});
    check_eq("s4.pad_err", 36'(a_pad), 36'd1);
    check_eq("s4.frames", 36'(fc_a), 36'd1);

    // 5: reset with two words queued
    do_reset();
    cyc(1'b1, 18'd1, 1'b1, 1'b0);
    for (int k = 2; k <= 4; k++) cyc(1'b1, 18'(k), 1'b0, 1'b0);
    check_eq("s5.queued", 36'(a_flag), 36'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("s5.rst_flag", 36'(a_flag), 36'd0);
    check_eq("s5.rst_pixel", a_pix, 36'd0);
    check_eq("s5.rst_state", 36'(a_dbg), 36'd0);
    check_eq("s5.rst_ff", 36'(a_ff), 36'd0);
    model_reset();
    @(negedge clock);
    compare_outputs();
    reset = 1'b1;
    log_a.delete(); fc_a = 0;
    normal_frame();
    check_words("s5.words", log_a, exp_q);
    check_eq("s5.frames", 36'(fc_a), 36'd1);

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      cyc(($urandom % 10) < 7, 18'($urandom), ($urandom % 20) == 0, ($urandom % 3) != 0);
      if (k == 750) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
